snax_tcdm_responder: RTL and testbench



---
 rtl/snax_tcdm_responder_if.sv | 28 ++
 rtl/snax_tcdm_responder.sv | 118 +++++++++++
 tb/tb_snax_tcdm_responder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snax_tcdm_responder_if.sv
// Request/response bundle between SNAX streamer TCDM ports and the responder model.
// Signal suffixes are relative to the responder (slave) side.
interface snax_tcdm_responder_if #(
    parameter int unsigned NumPorts      = 24,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TCDMAddrWidth = 48
);
    logic [NumPorts-1:0]                    tcdm_req_write_i;
    logic [NumPorts-1:0][TCDMAddrWidth-1:0] tcdm_req_addr_i;
    logic [NumPorts-1:0][DataWidth-1:0]     tcdm_req_data_i;
    logic [NumPorts-1:0][DataWidth/8-1:0]   tcdm_req_strb_i;
    logic [NumPorts-1:0]                    tcdm_req_q_valid_i;
    logic [NumPorts-1:0]                    tcdm_rsp_q_ready_o;
    logic [NumPorts-1:0]                    tcdm_rsp_p_valid_o;
    logic [NumPorts-1:0][DataWidth-1:0]     tcdm_rsp_data_o;

    modport master (
        output tcdm_req_write_i, tcdm_req_addr_i, tcdm_req_data_i, tcdm_req_strb_i,
               tcdm_req_q_valid_i,
        input  tcdm_rsp_q_ready_o, tcdm_rsp_p_valid_o, tcdm_rsp_data_o
    );

    modport slave (
        input  tcdm_req_write_i, tcdm_req_addr_i, tcdm_req_data_i, tcdm_req_strb_i,
               tcdm_req_q_valid_i,
        output tcdm_rsp_q_ready_o, tcdm_rsp_p_valid_o, tcdm_rsp_data_o
    );
endinterface

// File: rtl/snax_tcdm_responder.sv
// Multi-port, word-interleaved multi-bank TCDM memory model with per-bank round-robin
// arbitration, one-cycle read latency and a saturating bank-conflict stall counter.
module snax_tcdm_responder #(
    parameter int unsigned NumPorts      = 24,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TCDMAddrWidth = 48,
    parameter int unsigned NumBanks      = 32,
    parameter int unsigned BankDepth     = 512
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    snax_tcdm_responder_if.slave        tcdm,
    output logic [31:0]                 conflict_cnt_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned WO = $clog2(StrbWidth);
    localparam int unsigned BB = $clog2(NumBanks);
    localparam int unsigned RB = $clog2(BankDepth);
    localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [DataWidth-1:0] mem [NumBanks][BankDepth];

    logic [NumPorts-1:0][BB-1:0]        port_bank;
    logic [NumPorts-1:0][RB-1:0]        port_row;
    logic [NumBanks-1:0][PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NumBanks-1:0][PW-1:0]        win;
    logic [NumBanks-1:0]                bank_grant;
    logic [NumPorts-1:0]                q_ready;
    logic [NumPorts-1:0]                p_valid_q;
    logic [NumPorts-1:0][DataWidth-1:0] data_q;
    logic [31:0]                        cnt_q, cnt_d;
    logic                               unused_addr_bits;

    assign unused_addr_bits = ^tcdm.tcdm_req_addr_i;

    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            port_bank[i] = tcdm.tcdm_req_addr_i[i][WO +: BB];
            port_row[i]  = tcdm.tcdm_req_addr_i[i][WO+BB +: RB];
        end
    end

    // Per bank: first requester at or after the pointer, searched cyclically.
    always_comb begin
        int unsigned cand;
        logic [PW-1:0] idx;
        cand       = 0;
        idx        = '0;
        q_ready    = '0;
        bank_grant = '0;
        win        = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            for (int unsigned k = 0; k < NumPorts; k++) begin
                cand = 32'(rr_ptr_q[b]) + k;
                if (cand >= NumPorts) cand = cand - NumPorts;
                idx = PW'(cand);
                if (!bank_grant[b] && tcdm.tcdm_req_q_valid_i[idx] &&
                    port_bank[idx] == BB'(b)) begin
                    bank_grant[b] = 1'b1;
                    win[b]        = idx;
                    q_ready[idx]  = 1'b1;
                    rr_ptr_d[b]   = (idx == PW'(NumPorts - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
        if (rst_i) begin
            q_ready    = '0;
            bank_grant = '0;
        end
    end

    always_comb begin
        logic [32:0] sum;
        sum = {1'b0, cnt_q};
        for (int unsigned i = 0; i < NumPorts; i++) begin
            sum = sum + 33'(tcdm.tcdm_req_q_valid_i[i] & ~q_ready[i]);
        end
        cnt_d = sum[32] ? '1 : sum[31:0];
    end

    // Memory has no reset: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NumBanks; b++) begin
            if (bank_grant[b] && tcdm.tcdm_req_write_i[win[b]]) begin
                for (int unsigned s = 0; s < StrbWidth; s++) begin
                    if (tcdm.tcdm_req_strb_i[win[b]][s]) begin
                        mem[b][port_row[win[b]]][s*8 +: 8] <= tcdm.tcdm_req_data_i[win[b]][s*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            p_valid_q <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            for (int unsigned i = 0; i < NumPorts; i++) begin
                p_valid_q[i] <= q_ready[i] & ~tcdm.tcdm_req_write_i[i];
                if (q_ready[i] && !tcdm.tcdm_req_write_i[i]) begin
                    data_q[i] <= mem[port_bank[i]][port_row[i]];
                end
            end
        end
    end

    assign tcdm.tcdm_rsp_q_ready_o = q_ready;
    // A response due in a reset cycle is dropped.
    assign tcdm.tcdm_rsp_p_valid_o = p_valid_q & {NumPorts{~rst_i}};
    assign tcdm.tcdm_rsp_data_o    = data_q;
    assign conflict_cnt_o          = cnt_q;
endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Scoreboard bench for snax_tcdm_responder: reads push expectations at handshake,
// a negedge monitor pops and compares them when the responses are due.
module tb_snax_tcdm_responder;
    localparam int NP = 24;
    localparam int DW = 64;
    localparam int AW = 48;

    typedef struct {
        int          port;
        logic [63:0] data;
        bit          chk;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cnt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [63:0] model [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snax_tcdm_responder_if #(.NumPorts(NP), .DataWidth(DW), .TCDMAddrWidth(AW)) tcdm ();

    snax_tcdm_responder #(
        .NumPorts(NP), .DataWidth(DW), .TCDMAddrWidth(AW), .NumBanks(32), .BankDepth(512)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .tcdm(tcdm),
        .conflict_cnt_o(cnt)
    );

    // Word key: 8-byte words, 32 banks x 512 rows -> addr[16:3]; higher bits alias.
    function automatic int key_of(input logic [47:0] a);
        return int'(a[16:3]);
    endfunction

    task automatic clear_req();
        tcdm.tcdm_req_q_valid_i = '0;
        tcdm.tcdm_req_write_i   = '0;
        tcdm.tcdm_req_addr_i    = '0;
        tcdm.tcdm_req_data_i    = '0;
        tcdm.tcdm_req_strb_i    = '0;
    endtask

    task automatic drive(input int p, input bit w, input logic [47:0] a,
                         input logic [63:0] d, input logic [7:0] s);
        tcdm.tcdm_req_q_valid_i[p] = 1'b1;
        tcdm.tcdm_req_write_i[p]   = w;
        tcdm.tcdm_req_addr_i[p]    = a;
        tcdm.tcdm_req_data_i[p]    = d;
        tcdm.tcdm_req_strb_i[p]    = s;
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
        clear_req();
    endtask

    // Apply observed handshakes to the model; queue read expectations.
    task automatic note_cycle(input bit push_reads);
        for (int p = 0; p < NP; p++) begin
            if (tcdm.tcdm_req_q_valid_i[p] && tcdm.tcdm_rsp_q_ready_o[p]) begin
                int k;
                logic [63:0] v;
                k = key_of(tcdm.tcdm_req_addr_i[p]);
                if (tcdm.tcdm_req_write_i[p]) begin
                    v = model.exists(k) ? model[k] : 64'hx;
                    for (int b = 0; b < 8; b++)
                        if (tcdm.tcdm_req_strb_i[p][b]) v[b*8 +: 8] = tcdm.tcdm_req_data_i[p][b*8 +: 8];
                    model[k] = v;
                end else if (push_reads) begin
                    exp_t e;
                    e.port = p;
                    e.chk  = model.exists(k) && !$isunknown(model[k]);
                    e.data = e.chk ? model[k] : 64'h0;
                    e.due  = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic check_ready(input string name, input logic [NP-1:0] want);
        @(negedge clk);
        checks++;
        if (tcdm.tcdm_rsp_q_ready_o !== want) begin
            errors++;
            $display("FAIL %s q_ready got %h want %h", name, tcdm.tcdm_rsp_q_ready_o, want);
        end
    endtask

    always @(negedge clk) begin
        logic [NP-1:0] exp_v;
        logic [63:0]   exp_d [NP];
        bit            exp_c [NP];
        exp_t          e;
        exp_v = '0;
        for (int p = 0; p < NP; p++) begin
            exp_d[p] = '0;
            exp_c[p] = 1'b0;
        end
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            exp_v[e.port] = 1'b1;
            exp_d[e.port] = e.data;
            exp_c[e.port] = e.chk;
        end
        checks++;
        if (tcdm.tcdm_rsp_p_valid_o !== exp_v) begin
            errors++;
            $display("FAIL p_valid cyc %0d got %h want %h", cyc, tcdm.tcdm_rsp_p_valid_o, exp_v);
        end
        for (int p = 0; p < NP; p++) begin
            if (exp_v[p] && exp_c[p]) begin
                checks++;
                if (tcdm.tcdm_rsp_data_o[p] !== exp_d[p]) begin
                    errors++;
                    $display("FAIL rdata port %0d got %h want %h", p, tcdm.tcdm_rsp_data_o[p], exp_d[p]);
                end
            end
        end
    end

    task automatic test_reset();
        cycle_begin();
        drive(0, 1'b0, 48'h100, '0, '0);
        check_ready("reset_q_ready", '0);
        cycle_begin();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", cnt);
        end
        checks++;
        if (tcdm.tcdm_rsp_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", tcdm.tcdm_rsp_data_o[0]);
        end
    endtask

    task automatic test_conflict();
        // Preload via port 23 so the bank-0 pointer wraps back to 0.
        for (int i = 0; i < 3; i++) begin
            cycle_begin();
            drive(23, 1'b1, 48'(i * 'h100), 64'h1000 + 64'(i), 8'hFF);
            check_ready("preload", 24'h800000);
            note_cycle(1'b1);
        end
        cycle_begin();
        drive(0, 1'b0, 48'h000, '0, '0);
        drive(1, 1'b0, 48'h100, '0, '0);
        drive(2, 1'b0, 48'h200, '0, '0);
        check_ready("rr_first", 24'h000001);
        note_cycle(1'b1);
        cycle_begin();
        drive(1, 1'b0, 48'h100, '0, '0);
        drive(2, 1'b0, 48'h200, '0, '0);
        check_ready("rr_second", 24'h000002);
        note_cycle(1'b1);
        checks++;
        if (cnt !== 32'd2) begin
            errors++;
            $display("FAIL cnt_mid got %0d want 2", cnt);
        end
        cycle_begin();
        drive(2, 1'b0, 48'h200, '0, '0);
        check_ready("rr_third", 24'h000004);
        note_cycle(1'b1);
        cycle_begin();
        @(negedge clk);
        checks++;
        if (cnt !== 32'd3) begin
            errors++;
            $display("FAIL cnt_conflict got %0d want 3", cnt);
        end
    endtask

    task automatic test_write_read();
        cycle_begin();
        drive(0, 1'b1, 48'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        check_ready("wr_ready", 24'h000001);
        note_cycle(1'b1);
        cycle_begin();
        drive(0, 1'b0, 48'h100, '0, '0);
        check_ready("rd_ready", 24'h000001);
        note_cycle(1'b1);
        repeat (3) cycle_begin();
        @(negedge clk);
        checks++;
        if (tcdm.tcdm_rsp_data_o[0] !== 64'hDEADBEEF_CAFEF00D) begin
            errors++;
            $display("FAIL data_hold got %h want %h", tcdm.tcdm_rsp_data_o[0], 64'hDEADBEEF_CAFEF00D);
        end
    endtask

    task automatic test_strobe();
        cycle_begin();
        drive(5, 1'b1, 48'h200, 64'h1111111111111111, 8'hFF);
        check_ready("strb_w1", 24'h000020);
        note_cycle(1'b1);
        cycle_begin();
        drive(5, 1'b1, 48'h200, 64'h2222222222222222, 8'h0F);
        check_ready("strb_w2", 24'h000020);
        note_cycle(1'b1);
        cycle_begin();
        drive(5, 1'b0, 48'h200, '0, '0);
        check_ready("strb_rd", 24'h000020);
        note_cycle(1'b1);
        repeat (2) cycle_begin();
    endtask

    task automatic test_parallel();
        cycle_begin();
        for (int i = 0; i < NP; i++) drive(i, 1'b1, 48'(8 * i), {8{8'(i + 'h30)}} ^ 64'(i), 8'hFF);
        check_ready("par_write", '1);
        note_cycle(1'b1);
        cycle_begin();
        for (int i = 0; i < NP; i++) drive(i, 1'b0, 48'(8 * i), '0, '0);
        check_ready("par_read", '1);
        note_cycle(1'b1);
        repeat (2) cycle_begin();
        @(negedge clk);
        checks++;
        if (cnt !== 32'd3) begin
            errors++;
            $display("FAIL cnt_parallel got %0d want 3", cnt);
        end
    endtask

    task automatic test_alias();
        cycle_begin();
        drive(7, 1'b1, 48'h0_0000_0040, {8{8'hA5}}, 8'hFF);
        check_ready("alias_w", 24'h000080);
        note_cycle(1'b1);
        cycle_begin();
        drive(9, 1'b0, 48'h0_0002_0040, '0, '0);
        check_ready("alias_r", 24'h000200);
        note_cycle(1'b1);
        repeat (2) cycle_begin();
    endtask

    task automatic test_reset_mid();
        cycle_begin();
        drive(1, 1'b0, 48'h100, '0, '0);
        check_ready("mid_hs", 24'h000002);
        note_cycle(1'b0);
        cycle_begin();
        rst = 1'b1;
        drive(1, 1'b0, 48'h100, '0, '0);
        check_ready("mid_rst_ready", '0);
        checks++;
        if (tcdm.tcdm_rsp_p_valid_o !== '0) begin
            errors++;
            $display("FAIL mid_rst_pvalid got %h want 0", tcdm.tcdm_rsp_p_valid_o);
        end
        cycle_begin();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt !== 32'd0 || tcdm.tcdm_rsp_data_o[1] !== 64'h0) begin
            errors++;
            $display("FAIL mid_rst_state cnt %0d data %h want 0 and 0", cnt, tcdm.tcdm_rsp_data_o[1]);
        end
        cycle_begin();
        drive(1, 1'b0, 48'h100, '0, '0);
        check_ready("post_rst_rd", 24'h000002);
        note_cycle(1'b1);
        repeat (2) cycle_begin();
    endtask

    initial begin
        clear_req();
        test_reset();
        test_conflict();
        test_write_read();
        test_strobe();
        test_parallel();
        test_alias();
        test_reset_mid();
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
